ssp_fifo: RTL and testbench

//  Parametrised synchronous FIFO for the SSP datapath. It succeeds the fixed 8x16 PL022 TX/RX FIFOs.

---
 rtl/ssp_pkg.sv | 32 +++
 rtl/ssp_fifo_if.sv | 33 +++
 rtl/ssp_fifo.sv | 127 ++++++++++++
 tb/tb_ssp_fifo.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// Shared SSP definitions: parameter limits, SSPSR/SSPRIS bit positions
// and a legality helper used by the FIFO elaboration check.
package ssp_pkg;

    // Legal range of the stored word width (SSPCR0.DSS range)
    localparam int DATA_W_MIN = 4;
    localparam int DATA_W_MAX = 16;

    // Legal range of the FIFO depth
    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 256;

    // SSPSR bit positions
    localparam int SSPSR_TFE = 0;
    localparam int SSPSR_TNF = 1;
    localparam int SSPSR_RNE = 2;
    localparam int SSPSR_RFF = 3;
    localparam int SSPSR_BSY = 4;

    // SSPRIS bit positions
    localparam int SSPRIS_RORRIS = 0;
    localparam int SSPRIS_RTRIS  = 1;
    localparam int SSPRIS_RXRIS  = 2;
    localparam int SSPRIS_TXRIS  = 3;

    // True when a width/depth pair lies inside the supported limits
    function automatic bit fifo_params_legal(input int data_w, input int depth);
        return (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX) &&
               (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
    endfunction

endpackage

// File: rtl/ssp_fifo_if.sv
// Push/pop handshake bundle of the SSP FIFO.
// master: the side that produces words and consumes the head.
// slave:  the FIFO itself.
interface ssp_fifo_if #(
    parameter int DATA_W = 16
);

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr_valid,
        output wr_data,
        output rd_ready,
        input  wr_ready,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  rd_ready,
        output wr_ready,
        output rd_valid,
        output rd_data
    );

endinterface

// File: rtl/ssp_fifo.sv
// Parametrised first-word-fall-through FIFO for the SSP TX and RX paths.
// Keeps an explicit occupancy counter, registered empty/full/watermark
// flags and a sticky overrun bit. Pointers wrap explicitly, so any depth
// in range works, not just powers of two.
// Optional feature macro: SSP_FIFO_WM_PROG_EN -- when defined the watermark
// threshold comes from the wm_thresh port, otherwise it is DEPTH/2.
module ssp_fifo
    import ssp_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 8,
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             clr,
    ssp_fifo_if.slave        bus,
    output logic [LVL_W-1:0] level,
    output logic             empty,
    output logic             full,
    output logic             low_wm,
    output logic             high_wm,
    output logic             ovr,
    input  logic             ovr_clr
`ifdef SSP_FIFO_WM_PROG_EN
    ,
    input  logic [LVL_W-1:0] wm_thresh
`endif
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    if (!fifo_params_legal(DATA_W, DEPTH)) begin : g_bad_params
        $error("ssp_fifo: DATA_W/DEPTH outside supported limits");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_nxt;
    logic [LVL_W-1:0]  thresh;
    logic              do_push;
    logic              do_pop;
    logic              overrun;

`ifdef SSP_FIFO_WM_PROG_EN
    assign thresh = wm_thresh;
`else
    assign thresh = LVL_W'(DEPTH / 2);
`endif

    // Advance a pointer, wrapping from the last entry back to zero
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Handshake outputs follow the registered flags; the head word reads as zero while empty
    assign bus.wr_ready = !full;
    assign bus.rd_valid = !empty;
    assign bus.rd_data  = empty ? '0 : mem[rd_ptr];

    // Decide this cycle's push/pop/overrun and the occupancy after the edge
    always_comb begin
        do_pop    = !empty && bus.rd_ready;
        do_push   = bus.wr_valid && (!full || do_pop);
        overrun   = bus.wr_valid && full && !do_pop && !clr;
        level_nxt = level;
        if (clr) begin
            level_nxt = '0;
        end else if (do_push && !do_pop) begin
            level_nxt = level + 1'b1;
        end else if (do_pop && !do_push) begin
            level_nxt = level - 1'b1;
        end
    end

    // Storage write; contents are never reset because they are only visible when non-empty
    always_ff @(posedge PCLK) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers, occupancy and flags, all derived from the next-state level
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            low_wm  <= 1'b1;
            high_wm <= 1'b0;
        end else begin
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= next_ptr(wr_ptr);
                end
                if (do_pop) begin
                    rd_ptr <= next_ptr(rd_ptr);
                end
            end
            level   <= level_nxt;
            empty   <= (level_nxt == '0);
            full    <= (level_nxt == LVL_FULL);
            low_wm  <= (level_nxt <= thresh);
            high_wm <= (level_nxt >= thresh);
        end
    end

    // Sticky overrun: a new overrun beats a same-cycle clear, flush leaves it alone
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ovr <= 1'b0;
        end else if (overrun) begin
            ovr <= 1'b1;
        end else if (ovr_clr) begin
            ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ssp_fifo.sv
// Directed self-checking bench for ssp_fifo.
// Instance a: DEPTH=8, DATA_W=16 (fill/drain, overrun, full push+pop,
// watermarks, asynchronous reset mid-burst).
// Instance b: DEPTH=6 (watermark threshold, flush, non-power-of-two wrap).
// Honours SSP_FIFO_WM_PROG_EN when the build defines it.
module tb_ssp_fifo;

    localparam int LVL_A = $clog2(8 + 1);
    localparam int LVL_B = $clog2(6 + 1);
`ifdef SSP_FIFO_WM_PROG_EN
    localparam int THR_B = 2;
`else
    localparam int THR_B = 3;
`endif

    logic PCLK;
    logic PRESET;

    logic             clr_a, ovr_clr_a;
    logic [LVL_A-1:0] level_a;
    logic             empty_a, full_a, low_a, high_a, ovr_a;
    logic [LVL_A-1:0] wm_a;

    logic             clr_b, ovr_clr_b;
    logic [LVL_B-1:0] level_b;
    logic             empty_b, full_b, low_b, high_b, ovr_b;
    logic [LVL_B-1:0] wm_b;

    int n_checks = 0;
    int n_fail   = 0;

    ssp_fifo_if #(.DATA_W(16)) a_if ();
    ssp_fifo_if #(.DATA_W(16)) b_if ();

    ssp_fifo #(.DATA_W(16), .DEPTH(8)) u_dut_a (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .clr       (clr_a),
        .bus       (a_if),
        .level     (level_a),
        .empty     (empty_a),
        .full      (full_a),
        .low_wm    (low_a),
        .high_wm   (high_a),
        .ovr       (ovr_a),
        .ovr_clr   (ovr_clr_a)
`ifdef SSP_FIFO_WM_PROG_EN
        ,
        .wm_thresh (wm_a)
`endif
    );

    ssp_fifo #(.DATA_W(16), .DEPTH(6)) u_dut_b (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .clr       (clr_b),
        .bus       (b_if),
        .level     (level_b),
        .empty     (empty_b),
        .full      (full_b),
        .low_wm    (low_b),
        .high_wm   (high_b),
        .ovr       (ovr_b),
        .ovr_clr   (ovr_clr_b)
`ifdef SSP_FIFO_WM_PROG_EN
        ,
        .wm_thresh (wm_b)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [15:0] wd, input logic rr);
        a_if.wr_valid = wv;
        a_if.wr_data  = wd;
        a_if.rd_ready = rr;
        @(posedge PCLK);
        #1;
    endtask

    task automatic applyStimulusB(input logic wv, input logic [15:0] wd, input logic rr);
        b_if.wr_valid = wv;
        b_if.wr_data  = wd;
        b_if.rd_ready = rr;
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        PRESET = 1'b1;
        clr_a = 1'b0; ovr_clr_a = 1'b0; wm_a = LVL_A'(4);
        clr_b = 1'b0; ovr_clr_b = 1'b0; wm_b = LVL_B'(2);
        a_if.wr_valid = 1'b0; a_if.wr_data = '0; a_if.rd_ready = 1'b0;
        b_if.wr_valid = 1'b0; b_if.wr_data = '0; b_if.rd_ready = 1'b0;

        // Reset state
        #12;
        checkOutput("rst_empty",   32'(empty_a),       32'd1);
        checkOutput("rst_full",    32'(full_a),        32'd0);
        checkOutput("rst_level",   32'(level_a),       32'd0);
        checkOutput("rst_low",     32'(low_a),         32'd1);
        checkOutput("rst_high",    32'(high_a),        32'd0);
        checkOutput("rst_ovr",     32'(ovr_a),         32'd0);
        checkOutput("rst_rdvalid", 32'(a_if.rd_valid), 32'd0);
        checkOutput("rst_wrready", 32'(a_if.wr_ready), 32'd1);
        checkOutput("rst_rddata",  32'(a_if.rd_data),  32'd0);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;

        // Fill with 0x1111..0x8888, watermarks around threshold 4
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 16'(32'h1111 * i), 1'b0);
            checkOutput("fill_level", 32'(level_a),      32'(i));
            checkOutput("fill_head",  32'(a_if.rd_data), 32'h1111);
            checkOutput("fill_low",   32'(low_a),        32'(i <= 4));
            checkOutput("fill_high",  32'(high_a),       32'(i >= 4));
            checkOutput("fill_full",  32'(full_a),       32'(i == 8));
            checkOutput("fill_empty", 32'(empty_a),      32'd0);
        end
        checkOutput("full_wrready", 32'(a_if.wr_ready), 32'd0);

        // Overrun while full, then set-beats-clear, then clear
        applyStimulus(1'b1, 16'hDEAD, 1'b0);
        checkOutput("ovr_set",   32'(ovr_a),        32'd1);
        checkOutput("ovr_level", 32'(level_a),      32'd8);
        checkOutput("ovr_head",  32'(a_if.rd_data), 32'h1111);
        ovr_clr_a = 1'b1;
        applyStimulus(1'b1, 16'hDEAD, 1'b0);
        checkOutput("ovr_setwins", 32'(ovr_a), 32'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkOutput("ovr_cleared", 32'(ovr_a), 32'd0);
        ovr_clr_a = 1'b0;

        // Push with pop while full
        applyStimulus(1'b1, 16'hBEEF, 1'b1);
        checkOutput("fpp_level", 32'(level_a),      32'd8);
        checkOutput("fpp_ovr",   32'(ovr_a),        32'd0);
        checkOutput("fpp_full",  32'(full_a),       32'd1);
        for (int i = 2; i <= 8; i++) begin
            checkOutput("drain_data", 32'(a_if.rd_data), 32'(16'(32'h1111 * i)));
            applyStimulus(1'b0, 16'h0000, 1'b1);
        end
        checkOutput("drain_beef",  32'(a_if.rd_data), 32'hBEEF);
        checkOutput("drain_lvl1",  32'(level_a),      32'd1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("drain_empty", 32'(empty_a),       32'd1);
        checkOutput("drain_valid", 32'(a_if.rd_valid), 32'd0);
        checkOutput("drain_level", 32'(level_a),       32'd0);
        checkOutput("drain_rdata", 32'(a_if.rd_data),  32'd0);
        checkOutput("drain_low",   32'(low_a),         32'd1);
        checkOutput("drain_high",  32'(high_a),        32'd0);

        // Push and pop request while empty: only the push happens
        applyStimulus(1'b1, 16'h1234, 1'b1);
        checkOutput("epp_level", 32'(level_a),      32'd1);
        checkOutput("epp_head",  32'(a_if.rd_data), 32'h1234);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("epp_empty", 32'(empty_a), 32'd1);

        // Build level 5 with ovr set, then assert reset mid-burst
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'(32'hA000 + i), 1'b0);
        end
        applyStimulus(1'b1, 16'hFFFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b1);
        end
        checkOutput("pre_level", 32'(level_a),      32'd5);
        checkOutput("pre_head",  32'(a_if.rd_data), 32'hA003);
        checkOutput("pre_ovr",   32'(ovr_a),        32'd1);
        a_if.wr_valid = 1'b1;
        a_if.rd_ready = 1'b0;
        PRESET = 1'b1;
        #1;
        checkOutput("arst_empty", 32'(empty_a), 32'd1);
        checkOutput("arst_level", 32'(level_a), 32'd0);
        checkOutput("arst_ovr",   32'(ovr_a),   32'd0);
        checkOutput("arst_low",   32'(low_a),   32'd1);
        checkOutput("arst_high",  32'(high_a),  32'd0);
        #2;
        PRESET = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkOutput("post_rst_level", 32'(level_a), 32'd0);

        // Instance b: threshold behaviour at level 3
        for (int i = 1; i <= 3; i++) begin
            applyStimulusB(1'b1, 16'(32'h0B00 + i), 1'b0);
        end
        checkOutput("b_level3", 32'(level_b), 32'd3);
        checkOutput("b_high3",  32'(high_b),  32'd1);
        checkOutput("b_low3",   32'(low_b),   32'(3 <= THR_B));
`ifdef SSP_FIFO_WM_PROG_EN
        wm_b = LVL_B'(3);
        applyStimulusB(1'b0, 16'h0000, 1'b0);
        checkOutput("b_thr_change_low", 32'(low_b), 32'd1);
        wm_b = LVL_B'(7);
        applyStimulusB(1'b0, 16'h0000, 1'b0);
        checkOutput("b_thr_big_high", 32'(high_b), 32'd0);
        wm_b = LVL_B'(2);
`endif

        // Fill, overrun, move the read pointer, then flush with a push pending
        for (int i = 4; i <= 6; i++) begin
            applyStimulusB(1'b1, 16'(32'h0B00 + i), 1'b0);
        end
        checkOutput("b_full", 32'(full_b), 32'd1);
        applyStimulusB(1'b1, 16'h0BFF, 1'b0);
        checkOutput("b_ovr", 32'(ovr_b), 32'd1);
        applyStimulusB(1'b0, 16'h0000, 1'b1);
        checkOutput("b_level5", 32'(level_b), 32'd5);
        clr_b = 1'b1;
        applyStimulusB(1'b1, 16'h0BEE, 1'b1);
        clr_b = 1'b0;
        checkOutput("clr_level", 32'(level_b), 32'd0);
        checkOutput("clr_empty", 32'(empty_b), 32'd1);
        checkOutput("clr_low",   32'(low_b),   32'd1);
        checkOutput("clr_high",  32'(high_b),  32'd0);
        checkOutput("clr_full",  32'(full_b),  32'd0);
        checkOutput("clr_ovr",   32'(ovr_b),   32'd1);
        ovr_clr_b = 1'b1;
        applyStimulusB(1'b0, 16'h0000, 1'b0);
        ovr_clr_b = 1'b0;
        checkOutput("b_ovr_clr", 32'(ovr_b), 32'd0);

        // Pointer wrap over depth 6 with one word in flight
        applyStimulusB(1'b1, 16'h0C00, 1'b0);
        checkOutput("wrap_first", 32'(b_if.rd_data), 32'h0C00);
        for (int i = 1; i <= 20; i++) begin
            applyStimulusB(1'b1, 16'(32'h0C00 + i), 1'b1);
            checkOutput("wrap_data",  32'(b_if.rd_data), 32'(16'(32'h0C00 + i)));
            checkOutput("wrap_level", 32'(level_b),      32'd1);
        end
        applyStimulusB(1'b0, 16'h0000, 1'b1);
        checkOutput("wrap_empty", 32'(empty_b), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
